// File: rtl/pfd_offset_cal_ctrl.sv
//------------------------------------------------------------------------------
// pfd_offset_cal_ctrl
//
// Background offset calibration for a time-interleaved ADC. The controller
// visits slices one at a time. On each visit it averages 2**Navg_adc samples of
// that slice and nudges the slice's offset estimate by one LSB toward the
// observed mean. Means inside +/-DZ_hist_adc leave the offset unchanged.
// A visit is CLEAR -> ACCUM -> UPDATE -> NEXT. After slice Nti-1 the sweep
// wraps to slice 0 and sweep_done pulses for one cycle.
//
// Optional feature macro: PFD_CAL_EXT_LOAD_EN
//   When defined, en_ext_pfd_offset / ext_pfd_offset are added. While
//   en_ext_pfd_offset is high, the offsets load ext_pfd_offset every cycle and
//   the FSM is parked in IDLE. Calibration then resumes from the loaded values.
//
// Ports
//   clk                clock, rising edge
//   rst                asynchronous active-high reset
//   en_pfd_cal         level enable for the calibration loop
//   adc_valid          qualifies adcout for one cycle
//   adcout             packed signed slice words, slice k at [k*Nadc +: Nadc]
//   Navg_adc           averaging exponent (2**Navg_adc samples per visit)
//   DZ_hist_adc        unsigned deadzone magnitude
//   en_ext_pfd_offset  (PFD_CAL_EXT_LOAD_EN) external load enable
//   ext_pfd_offset     (PFD_CAL_EXT_LOAD_EN) external offset values
//   pfd_offset         packed signed offset estimate per slice
//   cal_slice          slice currently being measured
//   cal_busy           high whenever the FSM is not in IDLE
//   sweep_done         one-cycle pulse at the end of each full sweep
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module pfd_offset_cal_ctrl #(
    parameter int Nti    = 16,
    parameter int Nadc   = 8,
    parameter int Nrange = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_pfd_cal,
    input  logic                    adc_valid,
    input  logic [Nti*Nadc-1:0]     adcout,
    input  logic [Nrange-1:0]       Navg_adc,
    input  logic [Nrange-1:0]       DZ_hist_adc,
`ifdef PFD_CAL_EXT_LOAD_EN
    input  logic                    en_ext_pfd_offset,
    input  logic [Nti*Nadc-1:0]     ext_pfd_offset,
`endif
    output logic [Nti*Nadc-1:0]     pfd_offset,
    output logic [$clog2(Nti)-1:0]  cal_slice,
    output logic                    cal_busy,
    output logic                    sweep_done
);

    localparam int SLICE_W = $clog2(Nti);
    // Worst case is 2**(2**Nrange-1) samples at full scale. That needs
    // 2**Nrange-1 extra bits of headroom above the sample width.
    localparam int ACC_W   = Nadc + (1 << Nrange) - 1;
    // Wide enough to hold the largest sample count, 2**(2**Nrange-1).
    localparam int CNT_W   = (1 << Nrange);

    localparam logic signed [Nadc-1:0] OFF_MAX = {1'b0, {(Nadc-1){1'b1}}};
    localparam logic signed [Nadc-1:0] OFF_MIN = {1'b1, {(Nadc-1){1'b0}}};
    localparam logic signed [Nadc-1:0] OFF_ONE = {{(Nadc-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        UPDATE = 3'd3,
        NEXT   = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [SLICE_W-1:0]       slice_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [Nrange-1:0]        navg_q;
    logic [Nrange-1:0]        dz_q;
    logic signed [Nadc-1:0]   offset_q [Nti];

    logic                     ext_load;
    logic                     hold_idle;
    logic                     last_slice;
    logic                     last_sample;
    logic [CNT_W-1:0]         cnt_target;
    logic [Nadc-1:0]          sample;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  avg;
    logic signed [ACC_W-1:0]  dz_pos;
    logic signed [ACC_W-1:0]  dz_neg;
    logic signed [Nadc-1:0]   cur_off;
    logic signed [Nadc-1:0]   upd_off;

`ifdef PFD_CAL_EXT_LOAD_EN
    assign ext_load = en_ext_pfd_offset;
`else
    assign ext_load = 1'b0;
`endif

    // External load wins over the calibration enable; either one parks the FSM.
    assign hold_idle  = ~en_pfd_cal | ext_load;
    assign last_slice = (slice_q == SLICE_W'(Nti - 1));

    // Sample N closes the visit, where N = 2**navg_q is taken from the value
    // latched at CLEAR.
    assign cnt_target  = CNT_W'(1) << navg_q;
    assign last_sample = adc_valid && ((cnt_q + CNT_W'(1)) == cnt_target);

    //--------------------------------------------------------------------------
    // Datapath combinational helpers
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        sample = '0;
        for (int k = 0; k < Nti; k++) begin
            if (slice_q == SLICE_W'(k)) begin
                sample = adcout[k*Nadc +: Nadc];
            end
        end
    end

    assign sample_ext = {{(ACC_W-Nadc){sample[Nadc-1]}}, sample};

    // An arithmetic shift on a signed operand floors toward minus infinity.
    assign avg    = acc_q >>> navg_q;
    assign dz_pos = signed'({{(ACC_W-Nrange){1'b0}}, dz_q});
    assign dz_neg = -dz_pos;

    assign cur_off = offset_q[slice_q];

    always_comb begin
        upd_off = cur_off;
        if (avg > dz_pos) begin
            if (cur_off != OFF_MAX) begin
                upd_off = cur_off + OFF_ONE;
            end
        end else if (avg < dz_neg) begin
            if (cur_off != OFF_MIN) begin
                upd_off = cur_off - OFF_ONE;
            end
        end
    end

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments, so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (hold_idle) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CLEAR;
                CLEAR:   state_nxt = ACCUM;
                ACCUM:   if (last_sample) state_nxt = UPDATE;
                UPDATE:  state_nxt = NEXT;
                NEXT:    state_nxt = CLEAR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        cal_busy   = (state != IDLE);
        sweep_done = (state == NEXT) && last_slice;
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            navg_q  <= '0;
            dz_q    <= '0;
            // NOTE: the offset bank is a visible output that must read zero out
            // of reset, so it is built from flops with a reset rather than a RAM.
            for (int k = 0; k < Nti; k++) begin
                offset_q[k] <= '0;
            end
        end else if (hold_idle) begin
            // Leaving (or staying in) IDLE discards the partial visit. The
            // offsets are kept unless an external load is overriding them.
            slice_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef PFD_CAL_EXT_LOAD_EN
            if (ext_load) begin
                for (int k = 0; k < Nti; k++) begin
                    offset_q[k] <= ext_pfd_offset[k*Nadc +: Nadc];
                end
            end
`endif
        end else begin
            case (state)
                CLEAR: begin
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    navg_q <= Navg_adc;
                    dz_q   <= DZ_hist_adc;
                end
                ACCUM: begin
                    if (adc_valid) begin
                        acc_q <= acc_q + sample_ext;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                UPDATE: begin
                    offset_q[slice_q] <= upd_off;
                end
                NEXT: begin
                    slice_q <= last_slice ? '0 : slice_q + SLICE_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Output packing
    //--------------------------------------------------------------------------
    for (genvar g = 0; g < Nti; g++) begin : g_pack
        assign pfd_offset[g*Nadc +: Nadc] = offset_q[g];
    end

    assign cal_slice = slice_q;

endmodule

// File: tb/tb_pfd_offset_cal_ctrl.sv
`timescale 1ns/1ps

module tb_pfd_offset_cal_ctrl;

    localparam int NTI  = 16;
    localparam int NADC = 8;
    localparam int NR   = 4;
    localparam int W    = NTI * NADC;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_pfd_cal;
    logic          adc_valid;
    logic [W-1:0]  adcout;
    logic [NR-1:0] Navg_adc;
    logic [NR-1:0] DZ_hist_adc;
`ifdef PFD_CAL_EXT_LOAD_EN
    logic          en_ext_pfd_offset;
    logic [W-1:0]  ext_pfd_offset;
`endif
    logic [W-1:0]  pfd_offset;
    logic [3:0]    cal_slice;
    logic          cal_busy;
    logic          sweep_done;

    int checks = 0;
    int errors = 0;

    pfd_offset_cal_ctrl #(
        .Nti    (NTI),
        .Nadc   (NADC),
        .Nrange (NR)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .en_pfd_cal        (en_pfd_cal),
        .adc_valid         (adc_valid),
        .adcout            (adcout),
        .Navg_adc          (Navg_adc),
        .DZ_hist_adc       (DZ_hist_adc),
`ifdef PFD_CAL_EXT_LOAD_EN
        .en_ext_pfd_offset (en_ext_pfd_offset),
        .ext_pfd_offset    (ext_pfd_offset),
`endif
        .pfd_offset        (pfd_offset),
        .cal_slice         (cal_slice),
        .cal_busy          (cal_busy),
        .sweep_done        (sweep_done)
    );

    always #5 clk = ~clk;

    // Every slice gets base, except slice k which gets vk (k = -1: none).
    function automatic logic [W-1:0] fill(input logic [NADC-1:0] base, input int k,
                                          input logic [NADC-1:0] vk);
        logic [W-1:0] v;
        for (int i = 0; i < NTI; i++) begin
            v[i*NADC +: NADC] = (i == k) ? vk : base;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; return 1 ns after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst         = 1'b1;
        en_pfd_cal  = 1'b0;
        adc_valid   = 1'b0;
        adcout      = '0;
        Navg_adc    = '0;
        DZ_hist_adc = '0;
`ifdef PFD_CAL_EXT_LOAD_EN
        en_ext_pfd_offset = 1'b0;
        ext_pfd_offset    = '0;
`endif

        // ---- reset state
        tick(2);
        check("rst_pfd_offset", pfd_offset, '0);
        check("rst_cal_slice",  cal_slice,  4'd0);
        check("rst_cal_busy",   cal_busy,   1'b0);
        check("rst_sweep_done", sweep_done, 1'b0);

        // ---- slice 0 fed +5, Navg=2, DZ=1, continuous valid
        rst         = 1'b0;
        Navg_adc    = 4'd2;
        DZ_hist_adc = 4'd1;
        adcout      = fill(8'h00, 0, 8'h05);
        adc_valid   = 1'b1;
        en_pfd_cal  = 1'b1;
        tick(1);                                   // CLEAR, slice 0
        check("s1_busy_clear",  cal_busy,  1'b1);
        check("s1_slice_clear", cal_slice, 4'd0);
        tick(5);                                   // UPDATE cycle, not yet applied
        check("s1_pfd_in_update", pfd_offset, '0);
        tick(2);                                   // 7 cycles after CLEAR
        check("s1_pfd_after_7", pfd_offset, fill(8'h00, 0, 8'h01));
        check("s1_slice_next",  cal_slice,  4'd1);
        check("s1_no_sweep",    sweep_done, 1'b0);
        en_pfd_cal = 1'b0;
        tick(1);
        check("s1_idle_busy",  cal_busy,   1'b0);
        check("s1_idle_slice", cal_slice,  4'd0);
        check("s1_idle_pfd",   pfd_offset, fill(8'h00, 0, 8'h01));

        // ---- slice 0 samples +1,+1,-1,-2 with a gap; CLEAR-cycle sample dropped
        Navg_adc    = 4'd2;
        DZ_hist_adc = 4'd0;
        adc_valid   = 1'b0;
        en_pfd_cal  = 1'b1;
        tick(1);                                   // CLEAR
        adcout = fill(8'h00, 0, 8'd100); adc_valid = 1'b1; tick(1);   // dropped in CLEAR
        adcout = fill(8'h00, 0, 8'h01);                    tick(1);
        adcout = fill(8'h00, 0, 8'd100); adc_valid = 1'b0; tick(1);   // ignored
        adcout = fill(8'h00, 0, 8'h01);  adc_valid = 1'b1; tick(1);
        adcout = fill(8'h00, 0, 8'hFF);                    tick(1);
        adcout = fill(8'h00, 0, 8'hFE);                    tick(1);   // -> UPDATE
        adc_valid = 1'b0;
        check("s2_pfd_before_upd", pfd_offset, fill(8'h00, 0, 8'h01));
        tick(1);                                   // NEXT
        check("s2_pfd_dec", pfd_offset, '0);
        en_pfd_cal = 1'b0;
        tick(1);

        // ---- drop enable mid-ACCUM at slice 5, Navg=1, all slices +1
        Navg_adc    = 4'd1;
        DZ_hist_adc = 4'd0;
        adcout      = fill(8'h01, -1, 8'h00);
        adc_valid   = 1'b1;
        en_pfd_cal  = 1'b1;
        tick(1);                                   // CLEAR slice 0
        tick(27);                                  // ACCUM slice 5, one sample in
        check("s3_slice5",      cal_slice, 4'd5);
        check("s3_busy_accum",  cal_busy,  1'b1);
        en_pfd_cal = 1'b0;
        tick(1);
        check("s3_idle_busy",  cal_busy,   1'b0);
        check("s3_idle_slice", cal_slice,  4'd0);
        check("s3_pfd_kept",   pfd_offset, {{(W-40){1'b0}}, 40'h01_0101_0101});
        en_pfd_cal = 1'b1;
        tick(1);
        check("s3_restart_slice", cal_slice, 4'd0);
        check("s3_restart_busy",  cal_busy,  1'b1);

        // ---- asynchronous reset while running
        #2 rst = 1'b1;
        #1;
        check("s4_async_rst_pfd",  pfd_offset, '0);
        check("s4_async_rst_busy", cal_busy,   1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- all slices -3, Navg=0, DZ=0, 16 sweeps
        Navg_adc    = 4'd0;
        DZ_hist_adc = 4'd0;
        adcout      = fill(8'hFD, -1, 8'h00);
        adc_valid   = 1'b1;
        en_pfd_cal  = 1'b1;
        tick(1);                                   // cycle 0: CLEAR slice 0
        check("s5_sweep_c0", sweep_done, 1'b0);
        for (int i = 1; i < 1024; i++) begin
            tick(1);
            check("s5_sweep_done", sweep_done, ((i % 64) == 63) ? 1'b1 : 1'b0);
        end
        check("s5_pfd_m16", pfd_offset, fill(8'hF0, -1, 8'h00));

        // ---- slice 3 +127 for 200 sweeps, then -128 for 300 sweeps
        adcout = fill(8'h00, 3, 8'h7F);
        tick(200 * 64);
        check("s6_pfd_sat_pos",   pfd_offset, fill(8'hF0, 3, 8'h7F));
        check("s6_slice_last",    cal_slice,  4'd15);
        check("s6_sweep_at_last", sweep_done, 1'b1);
        adcout = fill(8'h00, 3, 8'h80);
        tick(300 * 64);
        check("s6_pfd_sat_neg", pfd_offset, fill(8'hF0, 3, 8'h80));

`ifdef PFD_CAL_EXT_LOAD_EN
        // ---- external load overrides calibration
        ext_pfd_offset    = fill(8'h10, -1, 8'h00);
        en_ext_pfd_offset = 1'b1;
        tick(1);
        check("s7_ext_pfd",  pfd_offset, fill(8'h10, -1, 8'h00));
        check("s7_ext_busy", cal_busy,   1'b0);
        en_ext_pfd_offset = 1'b0;
`endif

        // ---- reset asserted during UPDATE of slice 2
        adcout = '0;
        tick(1);                                   // CLEAR slice 0
        check("s8_slice0", cal_slice, 4'd0);
        tick(10);                                  // UPDATE slice 2
        check("s8_slice2", cal_slice, 4'd2);
        check("s8_busy",   cal_busy,  1'b1);
`ifdef PFD_CAL_EXT_LOAD_EN
        check("s8_pfd_resumed", pfd_offset, fill(8'h10, -1, 8'h00));
`else
        check("s8_pfd_held", pfd_offset, fill(8'hF0, 3, 8'h80));
`endif
        #2 rst = 1'b1;
        #1;
        check("s8_rst_pfd",   pfd_offset, '0);
        check("s8_rst_slice", cal_slice,  4'd0);
        check("s8_rst_busy",  cal_busy,   1'b0);
        check("s8_rst_sweep", sweep_done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        en_pfd_cal = 1'b0;
        tick(2);
        check("s8_idle_busy", cal_busy,   1'b0);
        check("s8_idle_pfd",  pfd_offset, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pfd_offset_cal_ctrl.md
PFD_OFFSET_CAL_CTRL -- requirements
Module: pfd_offset_cal_ctrl

Interface
REQ-001 SHALL have parameter Nti, default 16: number of time-interleaved ADC slices.
REQ-002 SHALL have parameter Nadc, default 8: ADC word width, two's complement.
REQ-003 SHALL have parameter Nrange, default 4: width of the averaging-exponent and deadzone controls.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port en_pfd_cal, input, 1 bit: level enable for the calibration loop.
REQ-007 SHALL have port adc_valid, input, 1 bit: strobe qualifying adcout for one cycle.
REQ-008 SHALL have port adcout, input, Nti*Nadc bits: packed slice outputs, slice k at bits [k*Nadc +: Nadc], signed.
REQ-009 SHALL have port Navg_adc, input, Nrange bits: averaging exponent; 2**Navg_adc samples per slice visit.
REQ-010 SHALL have port DZ_hist_adc, input, Nrange bits: unsigned deadzone magnitude.
REQ-011 SHALL have port pfd_offset, output, Nti*Nadc bits: packed signed offset estimate per slice.
REQ-012 SHALL have port cal_slice, output, $clog2(Nti) bits: slice currently being measured.
REQ-013 SHALL have port cal_busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port sweep_done, output, 1 bit: one-cycle pulse on completion of each full sweep over all slices.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, ACCUM, UPDATE, NEXT.
REQ-016 SHALL move IDLE->CLEAR on the first clk edge with en_pfd_cal=1, starting at cal_slice=0.
REQ-017 CLEAR SHALL, in one cycle, zero the accumulator and sample counter and latch Navg_adc and DZ_hist_adc for the visit.
REQ-018 ACCUM SHALL sign-extend and add adcout slice cal_slice on each adc_valid=1 cycle and ignore cycles with adc_valid=0.
REQ-019 The accumulator SHALL be Nadc+2**Nrange-1 bits signed and SHALL never overflow for any legal Navg_adc.
REQ-020 ACCUM->UPDATE SHALL occur on the edge that accepts sample number 2**Navg_adc.
REQ-021 UPDATE SHALL compute avg = accumulator arithmetically right-shifted by the latched Navg_adc, truncated toward minus infinity.
REQ-022 In UPDATE, if avg > +DZ the slice offset SHALL increment by 1, saturating at 2**(Nadc-1)-1.
REQ-023 In UPDATE, if avg < -DZ the slice offset SHALL decrement by 1, saturating at -2**(Nadc-1).
REQ-024 In UPDATE with -DZ <= avg <= +DZ, the slice offset SHALL hold.
REQ-025 adc_valid during CLEAR, UPDATE or NEXT SHALL be dropped.
REQ-026 NEXT SHALL advance cal_slice by 1 and go to CLEAR; from slice Nti-1 it SHALL wrap to 0 and assert sweep_done in that cycle.
REQ-027 en_pfd_cal=0 in any state SHALL force IDLE on the next edge, discard the partial accumulation, retain all pfd_offset values and reset cal_slice to 0.
REQ-028 Offsets for slices not in UPDATE SHALL never change.
REQ-029 Minimum visit length SHALL be 2**Navg_adc + 3 cycles with continuous adc_valid.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, pfd_offset=0, cal_slice=0, cal_busy=0, sweep_done=0, and zero the accumulator and counter.
REQ-031 Deassertion of rst SHALL be synchronised externally; the block SHALL begin operating on the first edge after release.

Configuration
REQ-032 SHALL recognise macro PFD_CAL_EXT_LOAD_EN.
REQ-033 With PFD_CAL_EXT_LOAD_EN defined, the block SHALL add inputs en_ext_pfd_offset (1 bit) and ext_pfd_offset (Nti*Nadc bits).
REQ-034 With PFD_CAL_EXT_LOAD_EN defined and en_ext_pfd_offset=1, pfd_offset SHALL load ext_pfd_offset every cycle and the FSM SHALL be held in IDLE; this overrides en_pfd_cal.
REQ-035 With PFD_CAL_EXT_LOAD_EN defined, calibration after en_ext_pfd_offset falls SHALL resume from the loaded values.
REQ-036 Without PFD_CAL_EXT_LOAD_EN, these ports and this logic SHALL be absent.

Verification
REQ-037 Bench SHALL cover: Navg=2, DZ=1, slice 0 fed +5 constant, continuous valid -> slice 0 offset=+1 after 7 cycles from CLEAR, other slices 0.
REQ-038 Bench SHALL cover: all slices fed -3, Navg=0, DZ=0 -> after 16 sweeps every offset=-16, with sweep_done pulsing once per 64 cycles.
REQ-039 Bench SHALL cover: slice 3 fed +127 for 200 sweeps -> offset saturates at +127; slice 3 fed -128 -> offset reaches -128 and holds.
REQ-040 Bench SHALL cover: slice 0 samples +1,+1,-1,-2, Navg=2, DZ=0 -> sum -1, avg -1 -> offset decrements by 1.
REQ-041 Bench SHALL cover: en_pfd_cal dropped mid-ACCUM at slice 5 -> IDLE next cycle, offsets unchanged; re-enable -> restarts at slice 0 with CLEAR.
REQ-042 Bench SHALL cover, with PFD_CAL_EXT_LOAD_EN: ext=0x10 all slices, en_ext=1 -> pfd_offset=0x10 and cal_busy=0; rst asserted mid-UPDATE -> all outputs 0 immediately.
